sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/fft_pkg.sv | 13 +
 rtl/feeder_fifo.sv | 53 +++++
 rtl/sample_feeder.sv | 126 ++++++++++++
 tb/tb_sample_feeder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the sample feeder front end.
package fft_pkg;

  localparam int unsigned FRAME_LEN_DEFAULT = 16;

  typedef logic [15:0] sample_t;

  typedef enum logic [0:0] {
    StRun,
    StClear
  } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Sample FIFO: register-file storage, wrapping pointers and an occupancy count (0..DEPTH).
module feeder_fifo
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic    clk,
  input  logic    nrst,
  input  logic    i_push,
  input  logic    i_pop,
  input  sample_t i_data,
  output sample_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sample_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sample_feeder.sv
// Feeds buffered samples to a frame accumulator and clears it between frames.
// Optional SAMPLE_FEEDER_OVF_EN adds a sticky frame-sum overflow flag.
module sample_feeder
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic [15:0] val_a,
  output logic        ce,
  output logic        acc_nrst,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
`ifdef SAMPLE_FEEDER_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam logic [7:0] LastIdx = 8'(FRAME_LEN - 1);

  feeder_state_t r_state;
  feeder_state_t w_state_d;
  logic          w_frame_done;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  sample_t       w_fifo_data;
  sample_t       r_val_a;
  logic          r_ce;
  logic          r_last;
  logic [7:0]    r_cnt;
  logic [7:0]    r_frame_cnt;
  logic          r_alive;

  assign s_ready    = nrst && !w_full;
  assign w_push     = s_valid && s_ready;
  // r_last holds off the next frame's first pop so CLEAR never overlaps a ce.
  assign w_pop      = (r_state == StRun) && !w_empty && !r_last;
  assign val_a      = r_val_a;
  assign ce         = r_ce;
  assign frame_done = w_frame_done;
  assign acc_nrst   = r_alive && (r_state != StClear);
  assign frame_cnt  = r_frame_cnt;

  feeder_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (s_data),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= StRun;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d    = r_state;
    w_frame_done = 1'b0;
    unique case (r_state)
      StRun: begin
        if (r_last) w_state_d = StClear;
      end
      StClear: begin
        w_frame_done = 1'b1;
        w_state_d    = StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_val_a     <= '0;
      r_ce        <= 1'b0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_frame_cnt <= '0;
      r_alive     <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_ce    <= w_pop;
      r_last  <= w_pop && (r_cnt == LastIdx);
      if (w_pop) begin
        r_val_a <= w_fifo_data;
        r_cnt   <= (r_cnt == LastIdx) ? 8'd0 : r_cnt + 8'd1;
      end
      if (r_state == StClear) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

`ifdef SAMPLE_FEEDER_OVF_EN
  logic [16:0] r_sum;
  logic        r_ovf;
  logic [17:0] w_sum_next;

  assign w_sum_next = {1'b0, r_sum} + {2'b00, w_fifo_data};
  assign ovf        = r_ovf;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == StClear) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= w_sum_next[16:0];
      if (w_sum_next[17]) r_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// Directed self-checking bench for sample_feeder (DEPTH=8, FRAME_LEN=16).
module tb_sample_feeder;

  logic        clk;
  logic        nrst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [15:0] val_a;
  logic        ce;
  logic        acc_nrst;
  logic        frame_done;
  logic [7:0]  frame_cnt;
`ifdef SAMPLE_FEEDER_OVF_EN
  logic        ovf;
`endif

  int          errors = 0;
  int          checks = 0;
  int          cyc;
  int          ce_cnt;
  int          done_cnt;
  int          last_ce;
  int          done_cyc;
  logic [15:0] exp_q[$];

  sample_feeder #(
    .DEPTH     (8),
    .FRAME_LEN (16)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .val_a      (val_a),
    .ce         (ce),
    .acc_nrst   (acc_nrst),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
`ifdef SAMPLE_FEEDER_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc      = 0;
    ce_cnt   = 0;
    done_cnt = 0;
    last_ce  = -1;
    done_cyc = -1;
    exp_q.delete();
  endtask

  // One clock: drive, advance past the edge, then score ce/val_a against the model queue.
  task automatic step(input logic v, input logic [15:0] d);
    s_valid = v;
    s_data  = d;
    if (v && s_ready) exp_q.push_back(d);
    @(posedge clk);
    #1;
    cyc++;
    if (ce) begin
      ce_cnt++;
      last_ce = cyc;
      chk("ce_has_data", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("order", val_a, exp_q.pop_front());
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    chk("acc_nrst_vs_clear", acc_nrst, !frame_done);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_data  = '0;
    nrst    = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_val_a", val_a, 16'h0000);
    chk("rst_ce", ce, 1'b0);
    chk("rst_acc_nrst", acc_nrst, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
`ifdef SAMPLE_FEEDER_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    chk("rel_s_ready", s_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("rel_acc_nrst", acc_nrst, 1'b1);
    clear_stats();
  endtask

  initial begin
    nrst    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    clear_stats();

    // Latency: push into empty FIFO at edge k, visible after edge k+1.
    do_reset();
    step(1'b1, 16'h1234);
    chk("lat_ce_k", ce, 1'b0);
    step(1'b0, 16'h0000);
    chk("lat_ce_k1", ce, 1'b1);
    chk("lat_val_k1", val_a, 16'h1234);
    step(1'b0, 16'h0000);
    chk("lat_ce_idle", ce, 1'b0);
    chk("lat_val_hold", val_a, 16'h1234);

    // One full frame of back-to-back ones.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0001);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000);
    chk("f1_ce_cnt", ce_cnt, 16);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_done_after_ce", done_cyc, last_ce + 1);
    chk("f1_frame_cnt", frame_cnt, 8'd1);
`ifdef SAMPLE_FEEDER_OVF_EN
    chk("f1_ovf", ovf, 1'b0);
`endif

    // Fill with pops blocked: ready drops at 8 entries, 9th refused, all 8 drain in order.
    do_reset();
    force dut.w_pop = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("fill_s_ready", s_ready, (i < 8) ? 1'b1 : 1'b0);
      step(1'b1, 16'hA000 + 16'(i));
    end
    chk("full_s_ready", s_ready, 1'b0);
    chk("full_q_depth", exp_q.size(), 8);
    release dut.w_pop;
    for (int i = 0; i < 12; i++) step(1'b0, 16'h0000);
    chk("drain_ce_cnt", ce_cnt, 8);
    chk("drain_q_empty", exp_q.size(), 0);
    chk("drain_s_ready", s_ready, 1'b1);

    // Gapped input: one sample every third cycle for two frames.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 16'h0100 + 16'(i));
      step(1'b0, 16'h0000);
      step(1'b0, 16'h0000);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000);
    chk("gap_ce_cnt", ce_cnt, 32);
    chk("gap_done_cnt", done_cnt, 2);
    chk("gap_frame_cnt", frame_cnt, 8'd2);
    chk("gap_q_empty", exp_q.size(), 0);

    // Reset in the middle of a frame discards the partial frame.
    for (int i = 0; i < 7; i++) step(1'b1, 16'h0200 + 16'(i));
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 16'h0300 + 16'(i));
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000);
    chk("mid_no_done_15", done_cnt, 0);
    chk("mid_frame_cnt_0", frame_cnt, 8'd0);
    step(1'b1, 16'h0400);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000);
    chk("mid_done_16", done_cnt, 1);
    chk("mid_ce_cnt", ce_cnt, 16);
    chk("mid_frame_cnt_1", frame_cnt, 8'd1);

`ifdef SAMPLE_FEEDER_OVF_EN
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'h3000);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000);
    chk("ovf_set", ovf, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0001);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000);
    chk("ovf_sticky", ovf, 1'b1);
    do_reset();
    chk("ovf_cleared", ovf, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
